inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Instruction fetch front end for the core pipeline. Drives a synchronous instruction memory that returns read data exactly one cycle after a request. Buffers returned words in a small FIFO and presents them to decode as a valid/stall stream, so decode never sees the memory's 1-cycle latency. Supports PC redirect (branch/jump flush), which discards buffered and in-flight instructions.

## Interface
- ADDR_W, 32, PC and memory address width (byte address)
- DATA_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- BUF_DEPTH, 2, instruction FIFO entries (power of two, ≥2)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- imem_en  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address; meaningful when imem_en=1
- imem_rdata  in  DATA_W  read data, valid the cycle after imem_en=1
- stall  in  1  decode cannot accept; head instruction held
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address (word aligned)
- inst_valid  out  1  inst/inst_pc hold a valid instruction
- inst  out  DATA_W  head instruction
- inst_pc  out  ADDR_W  PC of head instruction

## Operation
- State: pc register (next fetch address), inflight flag + inflight_pc (request issued last cycle), FIFO of {inst, pc} with count 0..BUF_DEPTH.
- pop = inst_valid & ~stall & ~redirect. inst_valid = (count != 0); inst/inst_pc = FIFO head.
- Issue rule (no redirect): imem_en = 1 iff (count + inflight − pop) < BUF_DEPTH. On issue: imem_addr = pc, pc ← pc + 4, inflight ← 1, inflight_pc ← pc; otherwise inflight ← 0.
- Response: if inflight=1 at a clock edge, {imem_rdata, inflight_pc} is pushed into FIFO at that edge. Issue rule guarantees no overflow; push and pop same edge allowed.
- Redirect (redirect=1, rst=0): FIFO emptied (count ← 0); in-flight response from the previous cycle discarded (not pushed); imem_en=1, imem_addr=redirect_pc this same cycle; pc ← redirect_pc + 4; inflight ← 1, inflight_pc ← redirect_pc. No pop occurs in a redirect cycle.
- Redirect dominates stall. stall has no effect on issue except through the credit rule.
- pc wraps modulo 2^ADDR_W; no alignment check on redirect_pc.

## Timing
- During rst: imem_en=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0; pc ← RESET_PC, inflight ← 0, count ← 0. Reset mid-operation drops FIFO and in-flight data; the rdata arriving the cycle after rst deasserts is ignored.
- First cycle after rst deasserts (C0): imem_en=1, imem_addr=RESET_PC. C1: fetch RESET_PC+4. C2: inst_valid=1, inst_pc=RESET_PC.
- Fetch-to-decode latency: 2 cycles (issue → push edge → visible). Redirect penalty: redirect in cycle R, first new instruction valid in R+2, inst_valid=0 in R+1.
- Throughput: 1 instruction/cycle sustained with stall=0 and BUF_DEPTH ≥ 2.
- Stall: head instruction and inst_pc stable while stall=1; with stall held, fetch issues until count + inflight = BUF_DEPTH, then imem_en=0. After stall drops, the next instruction appears the following cycle with no bubble.
- No outputs go X after reset; inst/inst_pc when inst_valid=0 are don't-care but must not change FIFO contents.

## Test plan
- Reset release, stall=0, memory word = address: inst_valid first high 2 cycles after rst drops; inst_pc sequence 0x0,0x4,0x8,... one per cycle, inst == inst_pc.
- Stall held 5 cycles once inst_pc=0x8 visible: inst_pc stays 0x8; imem_en drops after FIFO + inflight reach 2; on release, 0xC, 0x10 follow back-to-back with no bubble.
- Redirect to 0x100 while inst_pc=0x4 valid and 0x8 in flight: 0x8 never appears; next cycle inst_valid=0; then 0x100, 0x104,...
- Redirect and stall asserted together with full FIFO: FIFO flushed, imem_addr=0x200 that cycle, 0x200 valid two cycles later.
- rst asserted mid-stream for 1 cycle with a request in flight: stale rdata not delivered; stream restarts at RESET_PC with the 2-cycle latency.
- Random stall (50%) and occasional redirects, against a reference PC model: no lost, duplicated, or reordered instructions; FIFO never overflows.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: issues reads to a 1-cycle synchronous imem and
// buffers returned words in a small FIFO presented to decode as valid/stall.
module inst_fetch_unit #(
   parameter int unsigned        ADDR_W    = 32,
   parameter int unsigned        DATA_W    = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter int unsigned        BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              o_imem_en,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic [DATA_W-1:0] i_imem_rdata,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_inst_valid,
   output logic [DATA_W-1:0] o_inst,
   output logic [ADDR_W-1:0] o_inst_pc
);

   localparam int unsigned       PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned       CNT_W   = $clog2(BUF_DEPTH + 1);
   localparam int unsigned       OCC_W   = CNT_W + 1;
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   logic [ADDR_W-1:0] r_pc;
   logic              r_inflight;
   logic [ADDR_W-1:0] r_inflight_pc;
   logic [DATA_W-1:0] r_buf_inst [BUF_DEPTH];
   logic [ADDR_W-1:0] r_buf_pc   [BUF_DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_valid;
   logic              w_pop;
   logic              w_push;
   logic [OCC_W-1:0]  w_occ;
   logic              w_issue;
   logic [ADDR_W-1:0] w_fetch_addr;

   // Credit rule: never let buffered + in-flight words exceed the FIFO depth.
   assign w_valid      = (r_count != '0);
   assign w_pop        = w_valid & ~i_stall & ~i_redirect;
   assign w_push       = r_inflight & ~i_redirect;
   assign w_occ        = OCC_W'(r_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
   assign w_issue      = ~rst & (i_redirect | (w_occ < OCC_W'(BUF_DEPTH)));
   assign w_fetch_addr = i_redirect ? i_redirect_pc : r_pc;

   // Outputs are forced quiet during reset; an empty FIFO presents zeros.
   always_comb begin
      o_imem_en    = w_issue;
      o_imem_addr  = RESET_PC;
      o_inst_valid = 1'b0;
      o_inst       = '0;
      o_inst_pc    = '0;
      if (!rst) begin
         o_imem_addr  = w_fetch_addr;
         o_inst_valid = w_valid;
         if (w_valid) begin
            o_inst    = r_buf_inst[r_rd_ptr];
            o_inst_pc = r_buf_pc[r_rd_ptr];
         end
      end
   end

   // Control state: fetch PC, in-flight tracking and FIFO bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= RESET_PC;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else if (i_redirect) begin
         r_pc          <= i_redirect_pc + PC_STEP;
         r_inflight    <= 1'b1;
         r_inflight_pc <= i_redirect_pc;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
         r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         if (w_issue) begin
            r_pc          <= r_pc + PC_STEP;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
         end else begin
            r_inflight    <= 1'b0;
         end
      end
   end

   // FIFO storage needs no reset; it is only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_buf_inst[r_wr_ptr] <= i_imem_rdata;
         r_buf_pc[r_wr_ptr]   <= r_inflight_pc;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and randomised checks of inst_fetch_unit against a 1-cycle memory
// whose read word equals its address.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int n_checks = 0;
   int n_errors = 0;

   inst_fetch_unit #(
      .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .BUF_DEPTH(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .o_imem_en    (imem_en),
      .o_imem_addr  (imem_addr),
      .i_imem_rdata (imem_rdata),
      .i_stall      (stall),
      .i_redirect   (redirect),
      .i_redirect_pc(redirect_pc),
      .o_inst_valid (inst_valid),
      .o_inst       (inst),
      .o_inst_pc    (inst_pc)
   );

   always #5 clk = ~clk;

   // Memory returns the address as data one cycle later; garbage otherwise.
   always @(posedge clk) imem_rdata <= imem_en ? imem_addr : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Each cycle: drive inputs just after the falling edge, look 1ns later.
   task automatic step(input logic s, input logic r, input logic [31:0] rp);
      @(negedge clk);
      stall       = s;
      redirect    = r;
      redirect_pc = rp;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [31:0] exp_pc;
   logic        s_r, r_r;
   logic [31:0] rp_r;
   logic        prev_hold;
   logic [31:0] prev_pc;
   int          pops;

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

      // Reset state
      @(negedge clk); @(negedge clk); #1;
      chk("rst_imem_en",    32'(imem_en),    32'd0);
      chk("rst_imem_addr",  imem_addr,       32'h0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst",       inst,            32'h0);
      chk("rst_inst_pc",    inst_pc,         32'h0);

      // Reset release: 2-cycle latency then one instruction per cycle
      @(negedge clk); rst = 1'b0; #1;
      chk("c0_imem_en",   32'(imem_en),    32'd1);
      chk("c0_imem_addr", imem_addr,       32'h0);
      chk("c0_valid",     32'(inst_valid), 32'd0);
      step(0, 0, 0);
      chk("c1_imem_addr", imem_addr,       32'h4);
      chk("c1_valid",     32'(inst_valid), 32'd0);
      for (int c = 2; c < 8; c++) begin
         step(0, 0, 0);
         chk("seq_valid", 32'(inst_valid), 32'd1);
         chk("seq_pc",    inst_pc,         32'(4 * (c - 2)));
         chk("seq_inst",  inst,            32'(4 * (c - 2)));
      end

      // Stall held 5 cycles with 0x8 at the head
      do_reset(); #1;        // C0
      step(0, 0, 0);         // C1
      step(0, 0, 0);         // C2
      step(0, 0, 0);         // C3
      for (int c = 4; c < 9; c++) begin
         step(1, 0, 0);
         chk("stall_valid",   32'(inst_valid), 32'd1);
         chk("stall_pc",      inst_pc,         32'h8);
         chk("stall_imem_en", 32'(imem_en),    32'd0);
      end
      step(0, 0, 0);         // C9
      chk("rel_pc",        inst_pc,      32'h8);
      chk("rel_imem_en",   32'(imem_en), 32'd1);
      chk("rel_imem_addr", imem_addr,    32'h10);
      step(0, 0, 0);
      chk("rel_pc_c",  inst_pc,         32'hC);
      step(0, 0, 0);
      chk("rel_pc_10", inst_pc,         32'h10);
      chk("rel_valid", 32'(inst_valid), 32'd1);

      // Redirect while 0x4 is at the head and 0x8 is in flight
      do_reset(); #1;
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 1, 32'h100);   // C3
      chk("redir_head_pc",   inst_pc,      32'h4);
      chk("redir_imem_en",   32'(imem_en), 32'd1);
      chk("redir_imem_addr", imem_addr,    32'h100);
      step(0, 0, 0);
      chk("redir_bubble",    32'(inst_valid), 32'd0);
      chk("redir_next_addr", imem_addr,       32'h104);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0);
         chk("redir_valid", 32'(inst_valid), 32'd1);
         chk("redir_pc",    inst_pc,         32'h100 + 32'(4 * k));
      end

      // Redirect together with stall while the FIFO is full
      do_reset(); #1;
      step(0, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("full_imem_en", 32'(imem_en), 32'd0);
      step(1, 1, 32'h200);
      chk("rs_imem_en",   32'(imem_en), 32'd1);
      chk("rs_imem_addr", imem_addr,    32'h200);
      step(1, 0, 0);
      chk("rs_bubble", 32'(inst_valid), 32'd0);
      step(1, 0, 0);
      chk("rs_valid", 32'(inst_valid), 32'd1);
      chk("rs_pc",    inst_pc,         32'h200);
      chk("rs_inst",  inst,            32'h200);

      // One-cycle reset mid-stream with a request in flight
      do_reset(); #1;
      for (int c = 1; c < 5; c++) step(0, 0, 0);
      chk("mid_pc_before", inst_pc, 32'h8);
      @(negedge clk); rst = 1'b1; #1;
      chk("mid_rst_en",    32'(imem_en),    32'd0);
      chk("mid_rst_valid", 32'(inst_valid), 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      chk("mid_r0_addr",  imem_addr,       32'h0);
      chk("mid_r0_valid", 32'(inst_valid), 32'd0);
      step(0, 0, 0);
      chk("mid_r1_valid", 32'(inst_valid), 32'd0);
      step(0, 0, 0);
      chk("mid_r2_valid", 32'(inst_valid), 32'd1);
      chk("mid_r2_pc",    inst_pc,         32'h0);
      chk("mid_r2_inst",  inst,            32'h0);

      // Random stall and redirect against a reference PC model
      do_reset(); #1;
      exp_pc    = 32'h0;
      prev_hold = 1'b0;
      prev_pc   = '0;
      pops      = 0;
      for (int c = 0; c < 600; c++) begin
         s_r  = 1'($urandom_range(0, 1));
         r_r  = ($urandom_range(0, 15) == 0);
         rp_r = 32'($urandom_range(0, 1023)) << 2;
         step(s_r, r_r, rp_r);
         if (prev_hold) chk("rnd_hold_pc", inst_pc, prev_pc);
         if (r_r) begin
            chk("rnd_redir_en",   32'(imem_en), 32'd1);
            chk("rnd_redir_addr", imem_addr,    rp_r);
            exp_pc = rp_r;
         end else if (inst_valid && !s_r) begin
            chk("rnd_pc",   inst_pc, exp_pc);
            chk("rnd_inst", inst,    inst_pc);
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         prev_hold = inst_valid && s_r && !r_r;
         prev_pc   = inst_pc;
      end
      chk("rnd_progress", 32'(pops > 100), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
